// File: rtl/data_mem_responder_pkg.sv
// Shared constants for the data-side memory responder: MMIO word offsets,
// timer control bit positions and status bit positions.
package data_mem_responder_pkg;

  localparam logic [2:0] OFF_GPIO = 3'd0;
  localparam logic [2:0] OFF_CNT  = 3'd1;
  localparam logic [2:0] OFF_CMP  = 3'd2;
  localparam logic [2:0] OFF_CTRL = 3'd3;
  localparam logic [2:0] OFF_STAT = 3'd4;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_AUTOCLR = 1;
  localparam int CTRL_IRQEN   = 2;

  localparam int ST_MATCH = 0;
  localparam int ST_ERR   = 1;

  localparam logic [31:0] CMP_RST = 32'hFFFF_FFFF;

endpackage

// File: rtl/data_mem_responder_mmio_timer.sv
// Compare-match timer: COUNT, CMP, CTRL registers plus the sticky match bit
// with write-one-to-clear handling. Write strobes arrive already decoded.
module mmio_timer
  import data_mem_responder_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] wdata,
  input  logic        cnt_we,
  input  logic        cmp_we,
  input  logic        ctrl_we,
  input  logic        stat_we,
  output logic [31:0] count,
  output logic [31:0] cmp,
  output logic [2:0]  ctrl,
  output logic        match,
  output logic        irq
);

  logic [31:0] count_q, count_d;
  logic [31:0] cmp_q, cmp_d;
  logic [2:0]  ctrl_q, ctrl_d;
  logic        match_q, match_d;
  logic        hit;

  // The compare sees pre-edge COUNT/CMP; a software COUNT load does not mask it.
  assign hit = ctrl_q[CTRL_EN] && (count_q == cmp_q);

  always_comb begin
    count_d = count_q;
    cmp_d   = cmp_q;
    ctrl_d  = ctrl_q;
    match_d = match_q;

    if (cnt_we) begin
      count_d = wdata;
    end else if (ctrl_q[CTRL_EN]) begin
      if (hit && ctrl_q[CTRL_AUTOCLR]) count_d = 32'd0;
      else                             count_d = count_q + 32'd1;
    end

    if (cmp_we)  cmp_d  = wdata;
    if (ctrl_we) ctrl_d = wdata[2:0];

    // Hardware set is applied after the clear so it wins on a collision.
    if (stat_we && wdata[ST_MATCH]) match_d = 1'b0;
    if (hit)                        match_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= 32'd0;
      cmp_q   <= CMP_RST;
      ctrl_q  <= 3'd0;
      match_q <= 1'b0;
    end else begin
      count_q <= count_d;
      cmp_q   <= cmp_d;
      ctrl_q  <= ctrl_d;
      match_q <= match_d;
    end
  end

  assign count = count_q;
  assign cmp   = cmp_q;
  assign ctrl  = ctrl_q;
  assign match = match_q;
  assign irq   = match_q & ctrl_q[CTRL_IRQEN];

endmodule

// File: rtl/data_mem_responder.sv
// Data-side responder for the single-cycle core: word RAM plus an MMIO window
// (GPIO, timer, status). Reads are combinational, writes commit on clk.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int          DEPTH_WORDS = 64,
  parameter logic [31:0] MMIO_BASE   = 32'h0000_1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] dataadr,
  input  logic [31:0] writedata,
  input  logic        memwrite,
  output logic [31:0] readdata,
  output logic [31:0] gpio_out,
  output logic        timer_irq,
  output logic        err_flag
);

  localparam int AW = $clog2(DEPTH_WORDS);

  logic [31:0]   ram_mem [DEPTH_WORDS];
  logic [AW-1:0] ram_idx;
  logic          ram_hit, mmio_hit, unmapped;
  logic [2:0]    off;
  logic          gpio_we, cnt_we, cmp_we, ctrl_we, stat_we;
  logic [31:0]   gpio_q, gpio_d;
  logic          err_q, err_d;
  logic [31:0]   tmr_count, tmr_cmp;
  logic [2:0]    tmr_ctrl;
  logic          tmr_match;
  logic          unused_addr;

  // Byte lane bits are ignored: every access is a full word.
  assign unused_addr = ^dataadr[1:0];

  assign ram_idx  = dataadr[AW+1:2];
  assign off      = dataadr[4:2];
  assign ram_hit  = dataadr < 32'(DEPTH_WORDS * 4);
  assign mmio_hit = !ram_hit && (dataadr[31:5] == MMIO_BASE[31:5]);
  assign unmapped = !ram_hit && !mmio_hit;

  assign gpio_we = memwrite && mmio_hit && (off == OFF_GPIO);
  assign cnt_we  = memwrite && mmio_hit && (off == OFF_CNT);
  assign cmp_we  = memwrite && mmio_hit && (off == OFF_CMP);
  assign ctrl_we = memwrite && mmio_hit && (off == OFF_CTRL);
  assign stat_we = memwrite && mmio_hit && (off == OFF_STAT);

  mmio_timer u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .wdata   (writedata),
    .cnt_we  (cnt_we),
    .cmp_we  (cmp_we),
    .ctrl_we (ctrl_we),
    .stat_we (stat_we),
    .count   (tmr_count),
    .cmp     (tmr_cmp),
    .ctrl    (tmr_ctrl),
    .match   (tmr_match),
    .irq     (timer_irq)
  );

  // RAM is not reset; a store landing while reset is held is dropped.
  always_ff @(posedge clk) begin
    if (memwrite && ram_hit && rst_n) ram_mem[ram_idx] <= writedata;
  end

  always_comb begin
    gpio_d = gpio_q;
    err_d  = err_q;
    if (gpio_we) gpio_d = writedata;
    if (stat_we && writedata[ST_ERR]) err_d = 1'b0;
    if (memwrite && unmapped)         err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gpio_q <= 32'd0;
      err_q  <= 1'b0;
    end else begin
      gpio_q <= gpio_d;
      err_q  <= err_d;
    end
  end

  always_comb begin
    readdata = 32'd0;
    if (ram_hit) begin
      readdata = ram_mem[ram_idx];
    end else if (mmio_hit) begin
      case (off)
        OFF_GPIO: readdata = gpio_q;
        OFF_CNT:  readdata = tmr_count;
        OFF_CMP:  readdata = tmr_cmp;
        OFF_CTRL: readdata = {29'd0, tmr_ctrl};
        OFF_STAT: readdata = {30'd0, err_q, tmr_match};
        default:  readdata = 32'd0;
      endcase
    end
  end

  assign gpio_out = gpio_q;
  assign err_flag = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed self-checking bench for data_mem_responder.
module tb_data_mem_responder;

  localparam logic [31:0] A_GPIO = 32'h0000_1000;
  localparam logic [31:0] A_CNT  = 32'h0000_1004;
  localparam logic [31:0] A_CMP  = 32'h0000_1008;
  localparam logic [31:0] A_CTRL = 32'h0000_100C;
  localparam logic [31:0] A_STAT = 32'h0000_1010;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] dataadr = 32'd0;
  logic [31:0] writedata = 32'd0;
  logic        memwrite = 1'b0;
  logic [31:0] readdata;
  logic [31:0] gpio_out;
  logic        timer_irq;
  logic        err_flag;

  int compared = 0;
  int failed = 0;

  data_mem_responder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .dataadr   (dataadr),
    .writedata (writedata),
    .memwrite  (memwrite),
    .readdata  (readdata),
    .gpio_out  (gpio_out),
    .timer_irq (timer_irq),
    .err_flag  (err_flag)
  );

  always #5 clk = ~clk;

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    dataadr = a; writedata = d; memwrite = 1'b1;
    @(posedge clk);
    #1;
    memwrite = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    dataadr = a; memwrite = 1'b0;
    #1;
    d = readdata;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    #12;
    compared++; if (gpio_out !== 32'd0) begin failed++; $display("FAIL rst_gpio: got %h expected %h", gpio_out, 32'd0); end
    compared++; if (timer_irq !== 1'b0) begin failed++; $display("FAIL rst_irq: got %b expected 0", timer_irq); end
    compared++; if (err_flag !== 1'b0) begin failed++; $display("FAIL rst_err: got %b expected 0", err_flag); end
    rd(A_CMP, d);
    compared++; if (d !== 32'hFFFF_FFFF) begin failed++; $display("FAIL rst_cmp: got %h expected ffffffff", d); end
    rd(A_CNT, d);
    compared++; if (d !== 32'd0) begin failed++; $display("FAIL rst_cnt: got %h expected 0", d); end
    rd(A_STAT, d);
    compared++; if (d !== 32'd0) begin failed++; $display("FAIL rst_stat: got %h expected 0", d); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_ram();
    logic [31:0] d;
    wr(32'h0000_0010, 32'hDEAD_BEEF);
    rd(32'h0000_0010, d);
    compared++; if (d !== 32'hDEAD_BEEF) begin failed++; $display("FAIL ram_rd: got %h expected deadbeef", d); end
    rd(32'h0000_0013, d);
    compared++; if (d !== 32'hDEAD_BEEF) begin failed++; $display("FAIL ram_bytelane: got %h expected deadbeef", d); end
    wr(32'h0000_0000, 32'h1111_2222);
    wr(32'h0000_00FC, 32'h1234_5678);
    rd(32'h0000_00FC, d);
    compared++; if (d !== 32'h1234_5678) begin failed++; $display("FAIL ram_top: got %h expected 12345678", d); end
    rd(32'h0000_0000, d);
    compared++; if (d !== 32'h1111_2222) begin failed++; $display("FAIL ram_bottom: got %h expected 11112222", d); end
  endtask

  task automatic test_gpio_unmapped();
    logic [31:0] d;
    wr(A_GPIO, 32'h0000_00A5);
    compared++; if (gpio_out !== 32'h0000_00A5) begin failed++; $display("FAIL gpio_out: got %h expected a5", gpio_out); end
    rd(A_GPIO, d);
    compared++; if (d !== 32'h0000_00A5) begin failed++; $display("FAIL gpio_rd: got %h expected a5", d); end
    rd(32'h0000_1014, d);
    compared++; if (d !== 32'd0) begin failed++; $display("FAIL mmio_unused: got %h expected 0", d); end
    rd(32'h0000_8000, d);
    tick();
    compared++; if (d !== 32'd0 || err_flag !== 1'b0) begin failed++; $display("FAIL unmapped_rd: got %h/%b expected 0/0", d, err_flag); end
    wr(32'h0000_8000, 32'h0000_FFFF);
    compared++; if (err_flag !== 1'b1) begin failed++; $display("FAIL err_set: got %b expected 1", err_flag); end
    rd(32'h0000_0010, d);
    compared++; if (d !== 32'hDEAD_BEEF) begin failed++; $display("FAIL ram_untouched: got %h expected deadbeef", d); end
    rd(A_STAT, d);
    compared++; if (d !== 32'h2) begin failed++; $display("FAIL stat_err_rd: got %h expected 2", d); end
    wr(A_STAT, 32'h2);
    compared++; if (err_flag !== 1'b0) begin failed++; $display("FAIL err_w1c: got %b expected 0", err_flag); end
    wr(32'h0000_0100, 32'hBAD0_BAD0);
    rd(32'h0000_0000, d);
    compared++; if (err_flag !== 1'b1 || d !== 32'h1111_2222) begin failed++; $display("FAIL ram_end_unmapped: got %b/%h expected 1/11112222", err_flag, d); end
    wr(A_STAT, 32'h2);
  endtask

  task automatic test_timer_autoclr();
    logic [31:0] d;
    logic [31:0] s;
    wr(A_CMP, 32'd5);
    wr(A_CNT, 32'd0);
    wr(A_CTRL, 32'h7);
    rd(A_CNT, d);
    compared++; if (d !== 32'd0) begin failed++; $display("FAIL ac_start: got %h expected 0", d); end
    for (int i = 1; i <= 5; i++) begin
      tick();
      rd(A_CNT, d);
      rd(A_STAT, s);
      compared++; if (d !== 32'(i) || s !== 32'd0 || timer_irq !== 1'b0) begin failed++; $display("FAIL ac_step%0d: got %h/%h/%b expected %h/0/0", i, d, s, timer_irq, 32'(i)); end
    end
    tick();
    rd(A_CNT, d);
    rd(A_STAT, s);
    compared++; if (d !== 32'd0 || s !== 32'd1 || timer_irq !== 1'b1) begin failed++; $display("FAIL ac_match: got %h/%h/%b expected 0/1/1", d, s, timer_irq); end
    wr(A_CTRL, 32'h0);
    wr(A_STAT, 32'h1);
    compared++; if (timer_irq !== 1'b0) begin failed++; $display("FAIL ac_irq_clr: got %b expected 0", timer_irq); end
  endtask

  task automatic test_wrap();
    logic [31:0] d;
    logic [31:0] s;
    logic [31:0] exp_cnt [6] = '{32'hFFFF_FFFF, 32'd0, 32'd1, 32'd2, 32'd3, 32'd4};
    logic [31:0] exp_st  [6] = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd1};
    wr(A_CMP, 32'd3);
    wr(A_CNT, 32'hFFFF_FFFE);
    wr(A_CTRL, 32'h1);
    for (int i = 0; i < 6; i++) begin
      tick();
      rd(A_CNT, d);
      rd(A_STAT, s);
      compared++; if (d !== exp_cnt[i] || s !== exp_st[i]) begin failed++; $display("FAIL wrap_step%0d: got %h/%h expected %h/%h", i, d, s, exp_cnt[i], exp_st[i]); end
    end
    compared++; if (timer_irq !== 1'b0) begin failed++; $display("FAIL wrap_irq_masked: got %b expected 0", timer_irq); end
    wr(A_CTRL, 32'h0);
    wr(A_STAT, 32'h1);
  endtask

  task automatic test_simultaneous();
    logic [31:0] d;
    logic [31:0] s;
    wr(A_CMP, 32'd10);
    wr(A_CNT, 32'd8);
    wr(A_CTRL, 32'h1);
    tick();
    tick();
    wr(A_STAT, 32'h1);
    rd(A_CNT, d);
    rd(A_STAT, s);
    compared++; if (s !== 32'd1 || d !== 32'd11) begin failed++; $display("FAIL w1c_vs_set: got %h/%h expected 1/0000000b", s, d); end
    wr(A_STAT, 32'h1);
    rd(A_STAT, s);
    compared++; if (s !== 32'd0) begin failed++; $display("FAIL w1c_clear: got %h expected 0", s); end
    wr(A_CNT, 32'd10);
    wr(A_CNT, 32'd100);
    rd(A_CNT, d);
    rd(A_STAT, s);
    compared++; if (d !== 32'd100 || s !== 32'd1) begin failed++; $display("FAIL load_vs_hit: got %h/%h expected 00000064/1", d, s); end
    wr(A_STAT, 32'h0);
    rd(A_STAT, s);
    compared++; if (s !== 32'd1) begin failed++; $display("FAIL w0_noeffect: got %h expected 1", s); end
    wr(A_CTRL, 32'h0);
    wr(A_STAT, 32'h1);
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    wr(A_GPIO, 32'h0000_005A);
    wr(32'h0000_0020, 32'hCAFE_F00D);
    wr(32'h0000_8000, 32'h0);
    wr(A_CMP, 32'd2);
    wr(A_CNT, 32'd0);
    wr(A_CTRL, 32'h7);
    tick();
    tick();
    tick();
    compared++; if (timer_irq !== 1'b1) begin failed++; $display("FAIL pre_rst_irq: got %b expected 1", timer_irq); end
    wr(A_CMP, 32'd100);
    wr(A_CNT, 32'd5);
    tick();
    tick();
    rd(A_CNT, d);
    compared++; if (d !== 32'd7 || err_flag !== 1'b1) begin failed++; $display("FAIL pre_rst_cnt: got %h/%b expected 7/1", d, err_flag); end
    #2;
    rst_n = 1'b0;
    #1;
    compared++; if (gpio_out !== 32'd0 || timer_irq !== 1'b0 || err_flag !== 1'b0) begin failed++; $display("FAIL async_rst_out: got %h/%b/%b expected 0/0/0", gpio_out, timer_irq, err_flag); end
    rd(A_CNT, d);
    compared++; if (d !== 32'd0) begin failed++; $display("FAIL async_rst_cnt: got %h expected 0", d); end
    rd(A_CTRL, d);
    compared++; if (d !== 32'd0) begin failed++; $display("FAIL async_rst_ctrl: got %h expected 0", d); end
    dataadr = 32'h0000_0020; writedata = 32'h0; memwrite = 1'b1;
    tick();
    memwrite = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    rd(32'h0000_0020, d);
    compared++; if (d !== 32'hCAFE_F00D) begin failed++; $display("FAIL ram_survives_rst: got %h expected cafef00d", d); end
  endtask

  initial begin
    test_reset();
    test_ram();
    test_gpio_unmapped();
    test_timer_autoclr();
    test_wrap();
    test_simultaneous();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
